// File: rtl/opb_ppc2sim_pkg.sv
// Shared types for the PPC -> user-logic OPB software register.
// Bus <-> word bit-order helpers live here so both directions agree.
package opb_ppc2sim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  localparam logic [7:0] OFS_DATA   = 8'h00;
  localparam logic [7:0] OFS_COMMIT = 8'h04;

  // OPB bit 0 is the MSB; the fabric word puts it at bit 31.
  function automatic logic [31:0] to_word(
    input logic [0:31] bus
  );
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      w[31-i] = bus[i];
    end
    return w;
  endfunction

  function automatic logic [0:31] to_bus(
    input logic [31:0] word
  );
    logic [0:31] b;
    for (int i = 0; i < 32; i++) begin
      b[i] = word[31-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/opb_be_merge.sv
// Byte-enable merge: be_i[k] selects new_i byte k (byte 3 = MSB),
// otherwise the old byte is kept.
module opb_be_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  be_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int k = 0; k < 4; k++) begin
      if (be_i[k]) begin
        merged_o[8*k +: 8] = new_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/opb_register_ppc2simulink_sync.sv
// OPB slave software register, PPC writes / fabric reads, single clock.
// Optional double-buffering via PPC2SIM_SHADOW_EN (commit at offset 0x04).
module opb_register_ppc2simulink_sync
  import opb_ppc2sim_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6",
  parameter logic [31:0] C_INIT_VALUE = 32'h0
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  output logic [31:0]             user_data_out,
  output logic                    user_data_valid
);

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;

  logic        hit;
  logic        ack;
  logic        wr;
  logic        rd;
  logic [7:0]  ofs;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] merge_base;
  logic [31:0] merged;
  logic [3:0]  be;
  logic        unused_seq;

  assign unused_seq = OPB_seqAddr;

  assign hit = OPB_select
            && (OPB_ABus >= C_BASEADDR)
            && (OPB_ABus <= C_HIGHADDR);

  // Reset low kills an in-flight ack in the same cycle.
  assign ack   = (state_q == ACK) && OPB_select && OPB_Rst_n;
  assign wr    = ack && !OPB_RNW;
  assign rd    = ack && OPB_RNW;
  assign ofs   = OPB_ABus[C_OPB_AWIDTH-8:C_OPB_AWIDTH-1];
  assign wdata = to_word(OPB_DBus);
  assign be    = OPB_BE;

`ifdef PPC2SIM_SHADOW_EN
  logic [31:0] shadow_q, shadow_d;
  assign merge_base = shadow_q;
`else
  assign merge_base = data_q;
`endif

  opb_be_merge u_merge (
    .old_i    (merge_base),
    .new_i    (wdata),
    .be_i     (be),
    .merged_o (merged)
  );

  always_comb begin
    state_d = (state_q == IDLE && hit) ? ACK : IDLE;
    data_d  = data_q;
    valid_d = 1'b0;
    rdata   = '0;
`ifdef PPC2SIM_SHADOW_EN
    shadow_d = shadow_q;
    if (wr && ofs == OFS_DATA) begin
      shadow_d = merged;
    end
    if (wr && ofs == OFS_COMMIT) begin
      data_d  = shadow_q;
      valid_d = 1'b1;
    end
    case (ofs)
      OFS_DATA:   rdata = shadow_q;
      OFS_COMMIT: rdata = data_q;
      default:    rdata = '0;
    endcase
`else
    if (wr && ofs == OFS_DATA && be != 4'b0000) begin
      data_d  = merged;
      valid_d = 1'b1;
    end
    if (ofs == OFS_DATA) begin
      rdata = data_q;
    end
`endif
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q  <= IDLE;
      data_q   <= C_INIT_VALUE;
      valid_q  <= 1'b0;
`ifdef PPC2SIM_SHADOW_EN
      shadow_q <= C_INIT_VALUE;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef PPC2SIM_SHADOW_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign Sl_DBus         = rd ? to_bus(rdata) : '0;
  assign Sl_xferAck      = ack;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = data_q;
  assign user_data_valid = valid_q;

endmodule
